// File: rtl/config_stream_tx_if.sv
`timescale 1ns/1ps
// Host-side byte stream into config_stream_tx: valid/ready handshake carrying
// one config byte plus its target ID and segment framing flags.
interface config_stream_tx_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [7:0] s_id;
    logic       s_last;
    logic       s_eoc;

    modport master (
        output s_valid,
        output s_data,
        output s_id,
        output s_last,
        output s_eoc,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_id,
        input  s_last,
        input  s_eoc,
        output s_ready
    );
endinterface

// File: rtl/config_stream_tx.sv
`timescale 1ns/1ps
// Buffers host config segments and replays each as a contiguous one-byte-per-cycle
// burst on the tracing/configId/configData bus. Optional macro: CONFIG_STREAM_CHECKSUM_EN.
module config_stream_tx #(
    parameter int         FIFO_DEPTH = 64,
    parameter logic [7:0] IDLE_ID    = 8'hFF,
    parameter int         GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    config_stream_tx_if.slave host,
    output logic       tracing,
    output logic [7:0] configId,
    output logic [7:0] configData,
    output logic       busy,
    output logic       overflow
`ifdef CONFIG_STREAM_CHECKSUM_EN
    ,
    output logic [7:0] checksum,
    output logic       checksum_valid
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    // state   | meaning
    // IDLE    | tracing on, waiting for a complete segment
    // HALT    | tracing dropped, idle ID for GAP_CYCLES before the first burst
    // SEND    | one segment byte per cycle on the bus
    // GAP     | idle ID between segments; holds here until another segment is complete
    // RESUME  | idle ID for GAP_CYCLES, then tracing restored
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_SEND,
        ST_GAP,
        ST_RESUME
    } state_t;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
        logic       last;
        logic       eoc;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   seg_count;
    logic          full;
    logic          push;
    logic          pop;
    logic          in_seg;
    logic [7:0]    seg_id;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          cur_last;
    logic          cur_eoc;

    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign host.s_ready  = !full && !overflow;
    assign push          = host.s_valid && host.s_ready;
    assign head          = mem[rd_ptr[AW-1:0]];
    assign busy          = (state != ST_IDLE);

    // The target ID is latched from the first byte so a segment can never split across IDs.
    assign wr_entry = {(in_seg ? seg_id : host.s_id), host.s_data, host.s_last, host.s_eoc};

    // A segment is only started once fully resident, so popping inside SEND cannot underflow.
    assign pop = (((state == ST_HALT) || (state == ST_GAP)) && (gap_cnt == '0) && (seg_count != '0))
              || ((state == ST_SEND) && !cur_last);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            seg_count <= '0;
            overflow  <= 1'b0;
            in_seg    <= 1'b0;
            seg_id    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                in_seg <= !host.s_last;
                if (!in_seg) begin
                    seg_id <= host.s_id;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push && host.s_last, pop && head.last})
                2'b10:   seg_count <= seg_count + PTR_ONE;
                2'b01:   seg_count <= seg_count - PTR_ONE;
                default: seg_count <= seg_count;
            endcase
            // A full FIFO holding no complete segment can never drain; lock out the host.
            if (full && (seg_count == '0)) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tracing    <= 1'b1;
            configId   <= IDLE_ID;
            configData <= 8'h00;
            gap_cnt    <= '0;
            cur_last   <= 1'b0;
            cur_eoc    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (seg_count != '0) begin
                        state   <= ST_HALT;
                        tracing <= 1'b0;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_HALT, ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end else if (pop) begin
                        state      <= ST_SEND;
                        configId   <= head.id;
                        configData <= head.data;
                        cur_last   <= head.last;
                        cur_eoc    <= head.eoc;
                    end
                end
                ST_SEND: begin
                    if (cur_last) begin
                        state      <= cur_eoc ? ST_RESUME : ST_GAP;
                        configId   <= IDLE_ID;
                        configData <= 8'h00;
                        gap_cnt    <= GAP_LOAD;
                    end else begin
                        configId   <= head.id;
                        configData <= head.data;
                        cur_last   <= head.last;
                        cur_eoc    <= head.eoc;
                    end
                end
                ST_RESUME: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end else begin
                        state   <= ST_IDLE;
                        tracing <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tracing  <= 1'b1;
                    configId <= IDLE_ID;
                end
            endcase
        end
    end

`ifdef CONFIG_STREAM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum       <= 8'h00;
            checksum_valid <= 1'b0;
        end else begin
            checksum_valid <= (state == ST_RESUME) && (gap_cnt == '0);
            if ((state == ST_IDLE) && (seg_count != '0)) begin
                checksum <= 8'h00;
            end else if (pop) begin
                checksum <= checksum + head.data;
            end
        end
    end
`endif

endmodule
